// File: rtl/bcd_nibble_seq_pkg.sv
// Shared types and constants for the nibble-serial ADC/SBC sequencer.
package bcd_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam int NIB8  = 2;
   localparam int NIB16 = 4;
   localparam int IDX_W = 2;

   typedef logic [IDX_W-1:0] idx_t;

   // Index of the last nibble for each operand width.
   localparam idx_t LAST8  = idx_t'(NIB8 - 1);
   localparam idx_t LAST16 = idx_t'(NIB16 - 1);

endpackage

// File: rtl/bcd_nibble_seq_if.sv
// Request/result bundle between the ALU front end and the sequencer.
// Handshake: START is a one-cycle request, honoured only while the sequencer
// is in IDLE or FIN (it is dropped silently while BUSY=1); operands are
// captured on the START edge. DONE is a one-cycle pulse, and S/CO/VO/ZO/NO
// are valid from that cycle and held until the next DONE.
interface bcd_nibble_seq_if;
   import bcd_seq_pkg::*;

   logic        START;
   logic [15:0] A;
   logic [15:0] B;
   logic        CI;
   logic        ADD;
   logic        BCD;
   logic        W16;
   logic        BUSY;
   logic        DONE;
   logic [15:0] S;
   logic        CO;
   logic        VO;
   logic        ZO;
   logic        NO;
   state_t      DBG_STATE;

   modport master (
      output START, A, B, CI, ADD, BCD, W16,
      input  BUSY, DONE, S, CO, VO, ZO, NO, DBG_STATE
   );

   modport slave (
      input  START, A, B, CI, ADD, BCD, W16,
      output BUSY, DONE, S, CO, VO, ZO, NO, DBG_STATE
   );

endinterface

// File: rtl/bcd_nibble_seq_bcdadder.sv
// 4-bit adder slice, binary or packed-decimal, add or subtract.
// Subtract is A + ~B + CI, so CI=1 means "no borrow" and CO=0 means borrow.
module BCDAdder (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       CI,
   input  logic       ADD,
   input  logic       BCD,
   output logic [3:0] S,
   output logic       CO,
   output logic       VO
);

   logic [3:0] bb;
   logic [4:0] bin;

   // Binary sum first, then decimal correction of the nibble if requested.
   always_comb begin
      bb  = ADD ? B : ~B;
      bin = {1'b0, A} + {1'b0, bb} + {4'b0000, CI};
      // Signed overflow of the binary intermediate; in decimal mode this is
      // simply reported as-is.
      VO  = (A[3] == bb[3]) && (bin[3] != A[3]);
      S   = bin[3:0];
      CO  = bin[4];
      if (BCD) begin
         if (ADD) begin
            if (bin > 5'd9) begin
               S  = bin[3:0] + 4'd6;
               CO = 1'b1;
            end
         end else begin
            if (!bin[4]) begin
               S = bin[3:0] - 4'd6;
            end
         end
      end
   end

endmodule

// File: rtl/bcd_nibble_seq.sv
// Nibble-serial ADC/SBC sequencer: one shared 4-bit slice is walked over the
// latched operands, LS nibble first, with the carry registered between nibbles.
module bcd_nibble_seq
   import bcd_seq_pkg::*;
(
   input  logic               CLK,
   input  logic               RST_N,
   bcd_nibble_seq_if.slave    bus
);

   state_t      state_q, state_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic        add_q, add_d;
   logic        bcd_q, bcd_d;
   logic        w16_q, w16_d;
   idx_t        idx_q, idx_d;
   logic        cr_q, cr_d;
   logic        v_q, v_d;
   logic [15:0] res_q, res_d;
   logic [15:0] s_q, s_d;
   logic        co_q, co_d;
   logic        vo_q, vo_d;
   logic        zo_q, zo_d;
   logic        no_q, no_d;

   logic        accept;
   logic        last;
   logic [3:0]  nib_a, nib_b, slice_s;
   logic        slice_co, slice_vo;
   logic [15:0] res_ins, final_s;

   assign accept = bus.START && ((state_q == IDLE) || (state_q == FIN));
   assign last   = (idx_q == (w16_q ? LAST16 : LAST8));
   assign nib_a  = a_q[{idx_q, 2'b00} +: 4];
   assign nib_b  = b_q[{idx_q, 2'b00} +: 4];

   BCDAdder u_slice (
      .A   (nib_a),
      .B   (nib_b),
      .CI  (cr_q),
      .ADD (add_q),
      .BCD (bcd_q),
      .S   (slice_s),
      .CO  (slice_co),
      .VO  (slice_vo)
   );

   // State register and all datapath registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         add_q   <= 1'b0;
         bcd_q   <= 1'b0;
         w16_q   <= 1'b0;
         idx_q   <= '0;
         cr_q    <= 1'b0;
         v_q     <= 1'b0;
         res_q   <= '0;
         s_q     <= '0;
         co_q    <= 1'b0;
         vo_q    <= 1'b0;
         zo_q    <= 1'b1;
         no_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         add_q   <= add_d;
         bcd_q   <= bcd_d;
         w16_q   <= w16_d;
         idx_q   <= idx_d;
         cr_q    <= cr_d;
         v_q     <= v_d;
         res_q   <= res_d;
         s_q     <= s_d;
         co_q    <= co_d;
         vo_q    <= vo_d;
         zo_q    <= zo_d;
         no_q    <= no_d;
      end
   end

   // Next state: RUN lasts exactly one cycle per nibble; FIN may re-enter RUN.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (last)   state_d = FIN;
         FIN:     state_d = accept ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values: latch on accept, step one nibble per RUN cycle,
   // publish result and flags only on the final nibble.
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      add_d   = add_q;
      bcd_d   = bcd_q;
      w16_d   = w16_q;
      idx_d   = idx_q;
      cr_d    = cr_q;
      v_d     = v_q;
      res_d   = res_q;
      s_d     = s_q;
      co_d    = co_q;
      vo_d    = vo_q;
      zo_d    = zo_q;
      no_d    = no_q;

      res_ins = res_q;
      res_ins[{idx_q, 2'b00} +: 4] = slice_s;
      // In 8-bit mode the high byte passes A through untouched.
      final_s = w16_q ? res_ins : {a_q[15:8], res_ins[7:0]};

      if (accept) begin
         a_d   = bus.A;
         b_d   = bus.B;
         add_d = bus.ADD;
         bcd_d = bus.BCD;
         w16_d = bus.W16;
         idx_d = '0;
         cr_d  = bus.CI;
         v_d   = 1'b0;
         res_d = '0;
      end else if (state_q == RUN) begin
         res_d = res_ins;
         cr_d  = slice_co;
         v_d   = slice_vo;
         idx_d = idx_q + idx_t'(1);
         if (last) begin
            s_d  = final_s;
            co_d = slice_co;
            vo_d = slice_vo;
            zo_d = w16_q ? (final_s == 16'h0000) : (final_s[7:0] == 8'h00);
            no_d = w16_q ? final_s[15] : final_s[7];
         end
      end
   end

   // Outputs: status decoded from state, results straight from registers.
   always_comb begin
      bus.BUSY      = (state_q == RUN);
      bus.DONE      = (state_q == FIN);
      bus.DBG_STATE = state_q;
      bus.S         = s_q;
      bus.CO        = co_q;
      bus.VO        = vo_q;
      bus.ZO        = zo_q;
      bus.NO        = no_q;
   end

endmodule

// File: tb/tb_bcd_nibble_seq.sv
// Directed-vector bench for the nibble-serial ADC/SBC sequencer.
module tb_bcd_nibble_seq;
   import bcd_seq_pkg::*;

   logic clk;
   logic rst_n;
   int   n_vec = 0;
   int   n_err = 0;

   bcd_nibble_seq_if bus ();

   bcd_nibble_seq dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus.slave)
   );

   // Clock and reset.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Driver: called at a negedge; presents the request for one edge and
   // returns at the negedge after the START edge (sample point 1).
   task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                           input logic ci, input logic add, input logic bcd,
                           input logic w16);
      bus.A     = a;
      bus.B     = b;
      bus.CI    = ci;
      bus.ADD   = add;
      bus.BCD   = bcd;
      bus.W16   = w16;
      bus.START = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.START = 1'b0;
   endtask

   // Waits (bounded) for DONE, counting sample points since the START edge.
   task automatic wait_done(input int cnt0, input int exp_lat, input string tag);
      int cnt;
      logic both;
      cnt  = cnt0;
      both = 1'b0;
      while (bus.DONE !== 1'b1 && cnt < 30) begin
         if (bus.BUSY !== 1'b1) both = 1'b1;
         @(negedge clk);
         cnt++;
      end
      chk({tag, "_lat"}, 16'(cnt), 16'(exp_lat));
      chk({tag, "_busy_low_at_done"}, {15'b0, bus.BUSY}, 16'h0000);
      chk({tag, "_busy_through_run"}, {15'b0, both}, 16'h0000);
   endtask

   task automatic check_res(input string tag, input logic [15:0] s, input logic co,
                            input logic zo, input logic no);
      chk({tag, "_s"},  bus.S, s);
      chk({tag, "_co"}, {15'b0, bus.CO}, {15'b0, co});
      chk({tag, "_zo"}, {15'b0, bus.ZO}, {15'b0, zo});
      chk({tag, "_no"}, {15'b0, bus.NO}, {15'b0, no});
   endtask

   initial begin
      logic saw_done;
      rst_n     = 1'b0;
      bus.START = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      bus.CI    = 1'b0;
      bus.ADD   = 1'b0;
      bus.BCD   = 1'b0;
      bus.W16   = 1'b0;
      repeat (3) @(negedge clk);

      // Reset values.
      chk("rst_busy", {15'b0, bus.BUSY}, 16'h0000);
      chk("rst_done", {15'b0, bus.DONE}, 16'h0000);
      chk("rst_vo",   {15'b0, bus.VO},   16'h0000);
      check_res("rst", 16'h0000, 1'b0, 1'b1, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      // 8-bit BCD add: 45+38 = 83, high byte from A.
      start_op(16'h1245, 16'h0038, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("bcd8_busy", {15'b0, bus.BUSY}, 16'h0001);
      wait_done(1, 3, "bcd8");
      check_res("bcd8", 16'h1283, 1'b0, 1'b0, 1'b1);
      @(negedge clk);

      // 16-bit BCD add wrapping: 9999+0001 = 0000 carry 1.
      start_op(16'h9999, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b1);
      wait_done(1, 5, "bcd16");
      check_res("bcd16", 16'h0000, 1'b1, 1'b1, 1'b0);
      @(negedge clk);

      // 8-bit binary 7F+01: signed overflow.
      start_op(16'h007F, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
      wait_done(1, 3, "bin8v");
      check_res("bin8v", 16'h0080, 1'b0, 1'b0, 1'b1);
      chk("bin8v_vo", {15'b0, bus.VO}, 16'h0001);
      @(negedge clk);

      // 16-bit binary 0000-0001 = FFFF with borrow, then back-to-back BCD
      // 8-bit 10-01 = 09 issued while in FIN.
      start_op(16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1);
      wait_done(1, 5, "sub16");
      check_res("sub16", 16'hFFFF, 1'b0, 1'b0, 1'b1);
      chk("sub16_vo", {15'b0, bus.VO}, 16'h0000);
      start_op(16'h0010, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("b2b_busy", {15'b0, bus.BUSY}, 16'h0001);
      wait_done(1, 3, "bsub8");
      check_res("bsub8", 16'h0009, 1'b1, 1'b0, 1'b0);
      @(negedge clk);

      // 8-bit: B high byte ignored; AB12 + FF34 + 1 -> AB47.
      start_op(16'hAB12, 16'hFF34, 1'b1, 1'b1, 1'b0, 1'b0);
      wait_done(1, 3, "hi8");
      check_res("hi8", 16'hAB47, 1'b0, 1'b0, 1'b0);
      @(negedge clk);

      // 8-bit zero flag only over the low byte: 5500+0000 -> ZO=1.
      start_op(16'h5500, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
      wait_done(1, 3, "z8");
      check_res("z8", 16'h5500, 1'b0, 1'b1, 1'b0);
      @(negedge clk);

      // START and operand changes during RUN are ignored: 1234+1111 = 2345.
      start_op(16'h1234, 16'h1111, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("hold_mid_s", bus.S, 16'h5500);
      bus.A     = 16'hFFFF;
      bus.B     = 16'hFFFF;
      bus.CI    = 1'b1;
      bus.W16   = 1'b0;
      bus.START = 1'b1;
      @(negedge clk);
      bus.START = 1'b0;
      bus.A     = 16'h0000;
      bus.B     = 16'h4321;
      @(negedge clk);
      wait_done(3, 5, "ign");
      check_res("ign", 16'h2345, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      chk("stable_s",    bus.S, 16'h2345);
      chk("stable_done", {15'b0, bus.DONE}, 16'h0000);

      // Reset asserted mid-RUN of a 16-bit op: immediate abort, no DONE.
      start_op(16'h0F0F, 16'h0101, 1'b0, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", {15'b0, bus.BUSY}, 16'h0000);
      chk("arst_done", {15'b0, bus.DONE}, 16'h0000);
      check_res("arst", 16'h0000, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      rst_n    = 1'b1;
      saw_done = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus.DONE === 1'b1 || bus.BUSY === 1'b1) saw_done = 1'b1;
      end
      chk("arst_no_done", {15'b0, saw_done}, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
